// File: rtl/contador_modos_if.sv
// Data/control bundle for contador_modos: enable, mode select and load value in,
// registered count and ripple-carry flag out.
interface contador_modos_if;
  logic       ENB;
  logic [1:0] MODO;
  logic [3:0] D;
  logic [3:0] Q;
  logic       RCO;

  modport master (output ENB, output MODO, output D, input Q, input RCO);
  modport slave  (input ENB, input MODO, input D, output Q, output RCO);
endinterface

// File: rtl/contador_modos.sv
// 4-bit multi-mode counter (up, down-1, down-3, parallel load) with a one-cycle RCO pulse.
// Define CONTADOR_DOWN3_EN to enable the down-by-3 mode; otherwise MODO=10 holds.
module contador_modos (
  input  logic           CLK,
  input  logic           RST,
  contador_modos_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP    = 2'b00,
    MODE_DOWN1 = 2'b01,
    MODE_DOWN3 = 2'b10,
    MODE_LOAD  = 2'b11
  } modo_e;

  logic [3:0] q_q, q_d;
  logic       rco_q, rco_d;
  logic [4:0] arith;

  // Bit 4 of the widened result is the carry/borrow out of the 4-bit range.
  // Unknown or unused mode codes fall to the default and behave as a hold.
  always_comb begin
    q_d   = q_q;
    rco_d = 1'b0;
    arith = 5'd0;
    if (bus.ENB) begin
      case (bus.MODO)
        MODE_UP: begin
          arith = {1'b0, q_q} + 5'd1;
          q_d   = arith[3:0];
          rco_d = arith[4];
        end
        MODE_DOWN1: begin
          arith = {1'b0, q_q} - 5'd1;
          q_d   = arith[3:0];
          rco_d = arith[4];
        end
`ifdef CONTADOR_DOWN3_EN
        MODE_DOWN3: begin
          arith = {1'b0, q_q} - 5'd3;
          q_d   = arith[3:0];
          rco_d = arith[4];
        end
`endif
        MODE_LOAD: begin
          q_d   = bus.D;
          rco_d = 1'b0;
        end
        default: begin
          q_d   = q_q;
          rco_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= 4'd0;
      rco_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rco_q <= rco_d;
    end
  end

  assign bus.Q   = q_q;
  assign bus.RCO = rco_q;

endmodule

// File: tb/tb_contador_modos.sv
// Scoreboard bench for contador_modos: expected Q/RCO queued as each edge is driven,
// popped and compared once the edge has updated the outputs.
module tb_contador_modos;

  logic CLK;
  logic RST;

  contador_modos_if bus ();

  contador_modos dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       rst;
    logic       enb;
    logic [1:0] modo;
    logic [3:0] d;
    logic [3:0] eq;
    logic       erco;
  } vec_t;

  typedef struct {
    logic [3:0] q;
    logic       rco;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic applyStimulus(input logic rst, input logic enb,
                               input logic [1:0] modo, input logic [3:0] d);
    @(negedge CLK);
    RST      = rst;
    bus.ENB  = enb;
    bus.MODO = modo;
    bus.D    = d;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    vec_t v [2] = '{
      '{1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0},
      '{1'b1, 1'b1, 2'b00, 4'h5, 4'h0, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL reset step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  task automatic test_up_wrap();
    vec_t v [4] = '{
      '{1'b0, 1'b1, 2'b11, 4'hE, 4'hE, 1'b0},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'hF, 1'b0},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'h1, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL up_wrap step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  task automatic test_down1_wrap();
    vec_t v [4] = '{
      '{1'b0, 1'b1, 2'b11, 4'h1, 4'h1, 1'b0},
      '{1'b0, 1'b1, 2'b01, 4'h0, 4'h0, 1'b0},
      '{1'b0, 1'b1, 2'b01, 4'h0, 4'hF, 1'b1},
      '{1'b0, 1'b1, 2'b01, 4'h0, 4'hE, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL down1_wrap step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  task automatic test_down3();
`ifdef CONTADOR_DOWN3_EN
    vec_t v [4] = '{
      '{1'b0, 1'b1, 2'b11, 4'h4, 4'h4, 1'b0},
      '{1'b0, 1'b1, 2'b10, 4'h0, 4'h1, 1'b0},
      '{1'b0, 1'b1, 2'b10, 4'h0, 4'hE, 1'b1},
      '{1'b0, 1'b1, 2'b10, 4'h0, 4'hB, 1'b0}
    };
`else
    vec_t v [4] = '{
      '{1'b0, 1'b1, 2'b11, 4'h4, 4'h4, 1'b0},
      '{1'b0, 1'b1, 2'b10, 4'h0, 4'h4, 1'b0},
      '{1'b0, 1'b1, 2'b10, 4'h9, 4'h4, 1'b0},
      '{1'b0, 1'b1, 2'b10, 4'h0, 4'h4, 1'b0}
    };
`endif
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL down3 step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  // Also confirms a disabled edge clears a pending RCO pulse.
  task automatic test_enable_load();
    vec_t v [7] = '{
      '{1'b0, 1'b1, 2'b11, 4'hA, 4'hA, 1'b0},
      '{1'b0, 1'b0, 2'b00, 4'h3, 4'hA, 1'b0},
      '{1'b0, 1'b0, 2'b00, 4'h3, 4'hA, 1'b0},
      '{1'b0, 1'b0, 2'b00, 4'h3, 4'hA, 1'b0},
      '{1'b0, 1'b1, 2'b11, 4'hF, 4'hF, 1'b0},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'h0, 1'b1},
      '{1'b0, 1'b0, 2'b00, 4'h0, 4'h0, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 7; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL enable_load step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  task automatic test_reset_mid();
    vec_t v [4] = '{
      '{1'b0, 1'b1, 2'b11, 4'h6, 4'h6, 1'b0},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'h7, 1'b0},
      '{1'b1, 1'b1, 2'b00, 4'h0, 4'h0, 1'b0},
      '{1'b0, 1'b1, 2'b00, 4'h0, 4'h1, 1'b0}
    };
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{q: v[i].eq, rco: v[i].erco});
      applyStimulus(v[i].rst, v[i].enb, v[i].modo, v[i].d);
      e = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL reset_mid step %0d: got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  // Random mode/enable/reset mix against a behavioural reference of the counter.
  task automatic test_back_to_back();
    int   mq;
    int   nq;
    logic nr;
    logic rst, enb;
    logic [1:0] modo;
    logic [3:0] d;
    exp_t e;
    sb.push_back('{q: 4'h0, rco: 1'b0});
    applyStimulus(1'b1, 1'b0, 2'b00, 4'h0);
    e = sb.pop_front();
    compared++;
    if (bus.Q !== e.q || bus.RCO !== e.rco) begin
      mismatched++;
      $display("[TB] FAIL back_to_back reset: got Q=%b RCO=%b, want Q=%b RCO=%b",
               bus.Q, bus.RCO, e.q, e.rco);
    end
    mq = 0;
    for (int i = 0; i < 80; i++) begin
      rst  = ($urandom_range(0, 15) == 0);
      enb  = ($urandom_range(0, 3) != 0);
      modo = 2'($urandom_range(0, 3));
      d    = 4'($urandom_range(0, 15));
      nq   = mq;
      nr   = 1'b0;
      if (rst) begin
        nq = 0;
      end else if (enb) begin
        case (modo)
          2'b00: begin nq = (mq + 1) % 16;  nr = (mq == 15); end
          2'b01: begin nq = (mq + 15) % 16; nr = (mq == 0);  end
`ifdef CONTADOR_DOWN3_EN
          2'b10: begin nq = (mq + 13) % 16; nr = (mq < 3);   end
`endif
          2'b11: nq = int'(d);
          default: nq = mq;
        endcase
      end
      sb.push_back('{q: 4'(nq), rco: nr});
      applyStimulus(rst, enb, modo, d);
      mq = nq;
      e  = sb.pop_front();
      compared++;
      if (bus.Q !== e.q || bus.RCO !== e.rco) begin
        mismatched++;
        $display("[TB] FAIL back_to_back step %0d (rst=%b enb=%b modo=%b d=%b): got Q=%b RCO=%b, want Q=%b RCO=%b",
                 i, rst, enb, modo, d, bus.Q, bus.RCO, e.q, e.rco);
      end
    end
  endtask

  initial begin
    RST      = 1'b1;
    bus.ENB  = 1'b1;
    bus.MODO = 2'b00;
    bus.D    = 4'h0;
    test_reset();
    test_up_wrap();
    test_down1_wrap();
    test_down3();
    test_enable_load();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
